// File: rtl/hmem_arbiter_pkg.sv
// Shared types for the higher-memory arbiter: FSM states, requester identities,
// and small helpers that map between them.
package torrence_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } hmem_arb_state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } hmem_master_e;

  function automatic hmem_arb_state_e grant_state(input hmem_master_e m);
    return (m == ICACHE) ? GRANT_I : GRANT_D;
  endfunction

  function automatic hmem_master_e other_master(input hmem_master_e m);
    return (m == ICACHE) ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/reset_if.sv
// Reset bundle shared across the cache slice; rst_n is asynchronous, active-low.
interface reset_if;
  logic rst_n;

  modport sink   (input  rst_n);
  modport source (output rst_n);
endinterface

// File: rtl/hmem_arbiter_beat_counter.sv
// Burst beat counter: counts accepted beats and flags the last one of a line.
module hmem_beat_counter #(
  parameter int BEATS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic done
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] count_reg;

  // done is combinational so the FSM can leave the grant on the final beat itself
  assign done = incr && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (incr) begin
      count_reg <= done ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hmem_arbiter.sv
// Two-master (icache/dcache) arbiter onto one higher-memory port, one line burst per grant.
// Define HMEM_ARB_DCACHE_PRIORITY_EN to make dcache win every tie instead of round-robin.
module hmem_arbiter
  import torrence_types::*;
#(
  parameter int LINE_SIZE = 32,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  reset_if.sink           rst_if,

  input  logic            i_req,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            i_ready,
  output logic [XLEN-1:0] i_rdata,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,

  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ready,
  input  logic [XLEN-1:0] m_rdata
);

  localparam int BEATS = LINE_SIZE * 8 / XLEN;

  logic            rst_n;
  hmem_arb_state_e state_reg;
  hmem_arb_state_e tie_state;
  logic            beat;
  logic            beat_done;

  assign rst_n = rst_if.rst_n;

`ifdef HMEM_ARB_DCACHE_PRIORITY_EN
  assign tie_state = GRANT_D;
`else
  hmem_master_e last_grant_reg;

  assign tie_state = grant_state(other_master(last_grant_reg));
`endif

  // A beat only exists while granted; IDLE keeps m_req low so nothing counts there
  assign beat = (state_reg != IDLE) && m_req && m_ready;

  hmem_beat_counter #(
    .BEATS(BEATS)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_reg == IDLE),
    .incr  (beat),
    .done  (beat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
`ifndef HMEM_ARB_DCACHE_PRIORITY_EN
      last_grant_reg <= DCACHE;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_req && d_req) begin
            state_reg <= tie_state;
          end else if (i_req) begin
            state_reg <= GRANT_I;
          end else if (d_req) begin
            state_reg <= GRANT_D;
          end
        end
        // Grant is held until the full line moves, even if the owner pauses its request
        GRANT_I: begin
          if (beat_done) begin
            state_reg      <= IDLE;
`ifndef HMEM_ARB_DCACHE_PRIORITY_EN
            last_grant_reg <= ICACHE;
`endif
          end
        end
        GRANT_D: begin
          if (beat_done) begin
            state_reg      <= IDLE;
`ifndef HMEM_ARB_DCACHE_PRIORITY_EN
            last_grant_reg <= DCACHE;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pure steering from the registered grant; the loser always sees zeros
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    i_ready = 1'b0;
    i_rdata = '0;
    d_ready = 1'b0;
    d_rdata = '0;
    case (state_reg)
      GRANT_I: begin
        m_req   = i_req;
        m_we    = i_we;
        m_addr  = i_addr;
        m_wdata = i_wdata;
        i_ready = m_ready;
        i_rdata = m_rdata;
      end
      GRANT_D: begin
        m_req   = d_req;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        d_ready = m_ready;
        d_rdata = m_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hmem_arbiter.sv
// Directed bench for hmem_arbiter: expected beats are queued at stimulus time and a
// separate monitor checks each accepted memory beat against the queue head.
`timescale 1ns/1ps
module tb_hmem_arbiter;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;
  localparam logic [31:0] WR_KEY = 32'h0000_C3C3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  reset_if rst_if ();

  logic        i_req, i_we, i_ready, d_req, d_we, d_ready, m_req, m_we, m_ready;
  logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;

  hmem_arbiter #(.LINE_SIZE(32), .XLEN(32)) dut (
    .clk     (clk),
    .rst_if  (rst_if),
    .i_req   (i_req),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .m_rdata (m_rdata)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  // requester models
  bit          i_on = 0, d_on = 0, i_wr = 0, d_wr = 0;
  int          i_start = -1, d_start = -1, i_beat = 0, d_beat = 0;
  int          i_plo = -1, i_phi = -2, mr_lo = -1, mr_hi = -2;
  logic [31:0] i_base = '0, d_base = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic push_beat(input bit is_d, input logic [31:0] base, input int k,
                           input bit we, input int c);
    beat_t e;
    e.is_d = is_d;
    e.addr = base + 32'(4 * k);
    e.we   = we;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // rst_act: 0 = none, 1 = assert reset mid-cycle, 2 = release at cycle start
  task automatic step(input int rst_act);
    @(negedge clk);
    cyc++;
    if (rst_act == 2) rst_if.rst_n = 1'b1;
    if (cyc == i_start) begin i_on = 1; i_beat = 0; end
    if (cyc == d_start) begin d_on = 1; d_beat = 0; end
    i_req   = i_on && !(cyc >= i_plo && cyc <= i_phi);
    i_we    = i_req && i_wr;
    i_addr  = i_base + 32'(4 * i_beat);
    i_wdata = i_addr ^ WR_KEY;
    d_req   = d_on;
    d_we    = d_req && d_wr;
    d_addr  = d_base + 32'(4 * d_beat);
    d_wdata = d_addr ^ WR_KEY;
    m_ready = !(cyc >= mr_lo && cyc <= mr_hi);
    #1;
    m_rdata = m_addr ^ RD_KEY;
    if (rst_act == 1) begin
      chk("beat_before_reset", {d_ready, m_req}, 2'b11);
      rst_if.rst_n = 1'b0;
      d_on = 0;
    end
    #2;
    if (rst_if.rst_n) begin
      if (i_req && i_ready) begin i_beat++; if (i_beat == 8) i_on = 0; end
      if (d_req && d_ready) begin d_beat++; if (d_beat == 8) d_on = 0; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || i_on || d_on) && n < 80) begin
      step(0);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    exp_q.delete();
    i_on = 0;
    d_on = 0;
    repeat (2) step(0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_ctrl"}, {m_req, m_we, i_ready, d_ready}, 4'b0);
    chk({name, "_maddr"}, m_addr, 0);
    chk({name, "_mwdata"}, m_wdata, 0);
    chk({name, "_rdata"}, {i_rdata, d_rdata}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_if.rst_n = 1'b0;
    i_on = 0; d_on = 0;
    i_req = 1; i_we = 1; i_addr = 32'hDEAD_0000; i_wdata = 32'h1234_5678;
    d_req = 1; d_we = 1; d_addr = 32'hBEEF_0000; d_wdata = 32'h8765_4321;
    m_ready = 1; m_rdata = 32'hFFFF_FFFF;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_hold");
    i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rdata = 0;
    rst_if.rst_n = 1'b1;
  endtask

  // monitor: every accepted memory beat must match the head of the queue
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_if.rst_n === 1'b1 && m_req === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat at cycle %0d: addr %0h, no beat expected", cyc, m_addr);
        end else begin
          e = exp_q.pop_front();
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_owner", {i_ready, d_ready}, e.is_d ? 2'b01 : 2'b10);
          chk("beat_addr", m_addr, e.addr);
          chk("beat_we", m_we, e.we);
          chk("beat_wdata", m_wdata, e.addr ^ WR_KEY);
          chk("beat_rdata", e.is_d ? d_rdata : i_rdata, e.addr ^ RD_KEY);
          chk("loser_rdata", e.is_d ? i_rdata : d_rdata, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r;
    rst_if.rst_n = 1'b0;
    i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rdata = 0;
    do_reset();

    // icache alone, memory always ready
    t0 = cyc + 1;
    i_base = 32'h1000_0000; i_wr = 0; i_start = t0;
    for (int k = 0; k < 8; k++) push_beat(0, i_base, k, 0, t0 + 1 + k);
    repeat (10) step(0);
    chk("t1_idle_after_burst", {m_req, i_ready, d_ready}, 3'b0);
    drain();

    // simultaneous requests straight out of reset
    do_reset();
    t0 = cyc + 1;
    i_base = 32'h2000_0000; i_wr = 0; i_start = t0;
    d_base = 32'h3000_0000; d_wr = 1; d_start = t0;
`ifdef HMEM_ARB_DCACHE_PRIORITY_EN
    for (int k = 0; k < 8; k++) push_beat(1, d_base, k, 1, t0 + 1 + k);
    for (int k = 0; k < 8; k++) push_beat(0, i_base, k, 0, t0 + 10 + k);
`else
    for (int k = 0; k < 8; k++) push_beat(0, i_base, k, 0, t0 + 1 + k);
    for (int k = 0; k < 8; k++) push_beat(1, d_base, k, 1, t0 + 10 + k);
`endif
    repeat (10) step(0);
    chk("t2_gap_idle", {m_req, i_ready, d_ready}, 3'b0);
    drain();

    // dcache arrives on icache beat 3 and must wait for the whole line
    t0 = cyc + 1;
    i_base = 32'h4000_0000; i_wr = 0; i_start = t0;
    d_base = 32'h5000_0000; d_wr = 1; d_start = t0 + 3;
    for (int k = 0; k < 8; k++) push_beat(0, i_base, k, 0, t0 + 1 + k);
    for (int k = 0; k < 8; k++) push_beat(1, d_base, k, 1, t0 + 10 + k);
    repeat (10) step(0);
    chk("t3_gap_idle", {m_req, i_ready, d_ready}, 3'b0);
    drain();

    // memory stalls during beats 2-4
    t0 = cyc + 1;
    i_base = 32'h6000_0000; i_wr = 1; i_start = t0;
    mr_lo = t0 + 2; mr_hi = t0 + 4;
    for (int k = 0; k < 8; k++) push_beat(0, i_base, k, 1, (k == 0) ? t0 + 1 : t0 + 4 + k);
    repeat (4) step(0);
    chk("t4_stall_ready", {m_req, m_ready, i_ready}, 3'b100);
    chk("t4_stall_addr", m_addr, i_base + 32'd4);
    drain();

    // icache pauses after beat 5 for 10 cycles; dcache asks meanwhile
    t0 = cyc + 1;
    i_base = 32'h7000_0000; i_wr = 0; i_start = t0;
    i_plo = t0 + 6; i_phi = t0 + 15;
    d_base = 32'h8000_0000; d_wr = 0; d_start = t0 + 8;
    for (int k = 0; k < 5; k++) push_beat(0, i_base, k, 0, t0 + 1 + k);
    for (int k = 5; k < 8; k++) push_beat(0, i_base, k, 0, t0 + 11 + k);
    for (int k = 0; k < 8; k++) push_beat(1, d_base, k, 0, t0 + 20 + k);
    repeat (11) step(0);
    chk("t5_grant_held", {m_req, i_ready, d_ready}, 3'b010);
    chk("t5_addr_frozen", m_addr, i_base + 32'd20);
    drain();

    // reset lands on dcache beat 4 while icache is pending
    t0 = cyc + 1;
    d_base = 32'h9000_0000; d_wr = 1; d_start = t0;
    i_base = 32'hA000_0000; i_wr = 0; i_start = t0 + 4;
    for (int k = 0; k < 3; k++) push_beat(1, d_base, k, 1, t0 + 1 + k);
    repeat (4) step(0);
    step(1);
    check_zero_outputs("t6_async_reset");
    repeat (2) step(0);
    check_zero_outputs("t6_reset_held");
    r = cyc + 1;
    for (int k = 0; k < 8; k++) push_beat(0, i_base, k, 0, r + 1 + k);
    step(2);
    chk("t6_idle_after_release", {m_req, i_ready, d_ready}, 3'b0);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
